// File: rtl/dual_port_memory.sv
// dual_port_memory: byte-addressed unified memory with two request/response
// ports. The I-port is read-only (instruction fetch). The D-port reads and
// writes, with byte strobes on writes. Each port has a one-entry registered
// response, so a response appears one cycle after the request fires. Each
// port reports range and alignment errors.
//
// Parameters: AWIDTH, DWIDTH (multiple of 8), DEPTH (words), BASE_ADDR (byte
//   address of word 0). Array contents are undefined until written.
// Build option: define MEM_FWD_EN to forward D-port write bytes into an
//   I-port read of the same word in the same cycle. When MEM_FWD_EN is
//   undefined, the I-port returns the pre-write contents.
// Ports:
//   clk, rst (async, active-low)
//   i_req_valid/i_req_ready/i_addr           fetch request
//   i_rsp_valid/i_rsp_ready/i_rsp_data/err   fetch response
//   d_req_valid/d_req_ready/d_addr/d_we/
//     d_wdata/d_strb                         data request
//   d_rsp_valid/d_rsp_ready/d_rsp_data/err   data response (0 data on writes)
module dual_port_memory #(
    parameter int unsigned AWIDTH    = 32,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [AWIDTH-1:0]   i_addr,
    output logic                i_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [DWIDTH-1:0]   i_rsp_data,
    output logic                i_rsp_err,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [AWIDTH-1:0]   d_addr,
    input  logic                d_we,
    input  logic [DWIDTH-1:0]   d_wdata,
    input  logic [DWIDTH/8-1:0] d_strb,
    output logic                d_rsp_valid,
    input  logic                d_rsp_ready,
    output logic [DWIDTH-1:0]   d_rsp_data,
    output logic                d_rsp_err
);

    localparam int unsigned NB = DWIDTH / 8;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH-1:0] SPAN     = AWIDTH'(DEPTH * NB);
    localparam logic [DWIDTH-1:0] ERR_DATA = DWIDTH'(32'hDEAD_BEEF);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Address is inside the mapped window and word aligned (no wrap-around).
    function automatic logic in_map(input logic [AWIDTH-1:0] a);
        logic [AWIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < SPAN) && ((off % AWIDTH'(NB)) == '0);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [AWIDTH-1:0] a);
        return IW'((a - BASE_ADDR) / AWIDTH'(NB));
    endfunction

    logic          i_fire_c, d_fire_c;
    logic          i_ok_c, d_ok_c;
    logic          d_wr_en_c;
    logic [IW-1:0] i_idx_c, d_idx_c;
    logic [DWIDTH-1:0] i_rd_word_c, d_rd_word_c;

    assign i_req_ready = !i_rsp_valid || i_rsp_ready;
    assign d_req_ready = !d_rsp_valid || d_rsp_ready;
    assign i_fire_c    = i_req_valid && i_req_ready;
    assign d_fire_c    = d_req_valid && d_req_ready;

    // Unknown address or direction bits are treated as an illegal access.
    assign i_ok_c  = !$isunknown(i_addr) && in_map(i_addr);
    assign d_ok_c  = !$isunknown({d_addr, d_we}) && in_map(d_addr);
    assign i_idx_c = word_idx(i_addr);
    assign d_idx_c = word_idx(d_addr);

    // Writes never commit while reset is held.
    assign d_wr_en_c   = d_fire_c && d_we && d_ok_c && rst;
    assign d_rd_word_c = mem[d_idx_c];

    // I-port read word, optionally merged with a same-cycle D write.
    always_comb begin
        i_rd_word_c = mem[i_idx_c];
`ifdef MEM_FWD_EN
        if (d_wr_en_c && (d_idx_c == i_idx_c)) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (d_strb[b]) i_rd_word_c[8*b +: 8] = d_wdata[8*b +: 8];
            end
        end
`endif
    end

    // Byte-strobed array write.
    always_ff @(posedge clk) begin
        if (d_wr_en_c) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (d_strb[b]) mem[d_idx_c][8*b +: 8] <= d_wdata[8*b +: 8];
            end
        end
    end

    // I-port response register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rsp_valid <= 1'b0;
            i_rsp_data  <= '0;
            i_rsp_err   <= 1'b0;
        end else if (i_fire_c) begin
            i_rsp_valid <= 1'b1;
            i_rsp_err   <= !i_ok_c;
            i_rsp_data  <= i_ok_c ? i_rd_word_c : ERR_DATA;
        end else if (i_rsp_ready) begin
            i_rsp_valid <= 1'b0;
        end
    end

    // D-port response register; writes return zero data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_rsp_valid <= 1'b0;
            d_rsp_data  <= '0;
            d_rsp_err   <= 1'b0;
        end else if (d_fire_c) begin
            d_rsp_valid <= 1'b1;
            d_rsp_err   <= !d_ok_c;
            if (d_we) d_rsp_data <= '0;
            else      d_rsp_data <= d_ok_c ? d_rd_word_c : ERR_DATA;
        end else if (d_rsp_ready) begin
            d_rsp_valid <= 1'b0;
        end
    end

endmodule
